chunked_adder_seq: RTL

- Multi-cycle wide adder. Accepts one WIDTH-bit operand pair plus carry-in per transaction over a valid/ready handshake.
- Adds the operands CHUNK bits per cycle, least-significant slice first, by instantiating one configurable_full_adder with WIDTH=CHUNK. The carry is registered between slices.
- Returns the registered sum and carry-out over a second valid/ready handshake.
- Upstream feeder stage for the team's configurable_full_adder. Lets wide additions run through a narrow adder at reduced area.

---
 rtl/chunked_adder_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/chunked_adder_seq.sv
// Multi-cycle wide adder: one WIDTH-bit operand pair per transaction, summed
// CHUNK bits per cycle through a single narrow configurable_full_adder with the
// inter-slice carry held in a register. Valid/ready handshakes on both sides.

// Narrow combinational adder used as the per-slice arithmetic unit.
module configurable_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Plain ripple add with the carry folded into the top bit
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

endmodule

module chunked_adder_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_next;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic [CHUNK-1:0]   a_slice;
    logic [CHUNK-1:0]   b_slice;
    logic [CHUNK-1:0]   add_sum;
    logic               add_cout;

    assign last = (idx == IDX_W'(NUM_CHUNKS - 1));

    // Select the current operand slices; the loop keeps every part-select constant
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (idx == IDX_W'(i)) begin
                a_slice = a_reg[i*CHUNK +: CHUNK];
                b_slice = b_reg[i*CHUNK +: CHUNK];
            end
        end
    end

    configurable_full_adder #(
        .WIDTH (CHUNK)
    ) u_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Work word with the current slice replaced, so the final edge can publish
    // the complete result including the slice being written on that edge
    always_comb begin
        work_next = work;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (idx == IDX_W'(i)) begin
                work_next[i*CHUNK +: CHUNK] = add_sum;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, slice-by-slice accumulation and result publication
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            work      <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    work      <= work_next;
                    carry_reg <= add_cout;
                    if (last) begin
                        sum  <= work_next;
                        cout <= add_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
